divider_pipe_sx: RTL and testbench

Fully pipelined, parametrised integer divider accepting one operation per cycle, selectable per operation between unsigned and two's-complement signed division. Successor to `divider_top`. Adds:
- independent operand widths
- per-sample signed mode
- divide-by-zero and signed-overflow flags
- a sideband tag carried alongside each operation
- a global pipeline stall

Sits in datapaths needing sustained-throughput quotient/remainder with a fixed, known latency.

---
 rtl/divider_pkg.sv | 22 ++
 rtl/divider_pipe_stage.sv | 65 ++++++
 rtl/divider_pipe_sx.sv | 156 +++++++++++++++
 tb/tb_divider_pipe_sx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and helpers for the pipelined divider.
//   sideband_t       : per-operation control bits that travel with the data
//   SIDEBAND_IDLE    : empty pipeline slot (bubble / reset value)
//   divider_latency  : input-to-output latency in enabled cycles
package divider_pkg;

  typedef struct packed {
    logic valid;
    logic is_signed;
    logic q_neg;
    logic r_neg;
    logic div_zero;
    logic overflow;
  } sideband_t;

  localparam sideband_t SIDEBAND_IDLE = '0;

  function automatic int divider_latency(input int dividend_width);
    return dividend_width + 2;
  endfunction

endpackage

// File: rtl/divider_pipe_stage.sv
// One registered restoring-division step.
// Bit STAGE (counted from the MSB) of in_num is shifted into the partial
// remainder. That bit position is then overwritten with the quotient bit, so
// num carries the finished quotient bits above it and the unconsumed dividend
// bits below it.
// Ports:
//   in_clk, reset, in_enable     : clock, sync active-high reset, advance
//   in_num / out_num             : mixed quotient/dividend word
//   in_rem / out_rem             : partial remainder
//   in_den / out_den             : divisor magnitude
//   in_sb / out_sb, in_tag/out_tag : sideband and tag carried in lockstep
module divider_pipe_stage
  import divider_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = 8,
  parameter int DIVIDER_WIDTH  = 8,
  parameter int TAG_WIDTH      = 4,
  parameter int STAGE          = 0
) (
  input  logic                      in_clk,
  input  logic                      reset,
  input  logic                      in_enable,
  input  logic [DIVIDEND_WIDTH-1:0] in_num,
  input  logic [DIVIDER_WIDTH-1:0]  in_rem,
  input  logic [DIVIDER_WIDTH-1:0]  in_den,
  input  sideband_t                 in_sb,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  output logic [DIVIDEND_WIDTH-1:0] out_num,
  output logic [DIVIDER_WIDTH-1:0]  out_rem,
  output logic [DIVIDER_WIDTH-1:0]  out_den,
  output sideband_t                 out_sb,
  output logic [TAG_WIDTH-1:0]      out_tag
);

  localparam int BIT_POS = DIVIDEND_WIDTH - 1 - STAGE;

  logic [DIVIDER_WIDTH:0]    rem_shift;
  logic [DIVIDER_WIDTH:0]    rem_sub;
  logic                      q_bit;
  logic [DIVIDEND_WIDTH-1:0] num_next;

  // The restored remainder is always below the divisor, so it fits back into
  // DIVIDER_WIDTH bits. With a zero divisor every step subtracts nothing, which
  // naturally leaves all-ones quotient bits and the dividend in the remainder.
  always_comb begin
    rem_shift        = {in_rem, in_num[BIT_POS]};
    rem_sub          = rem_shift - {1'b0, in_den};
    q_bit            = (rem_shift >= {1'b0, in_den});
    num_next         = in_num;
    num_next[BIT_POS] = q_bit;
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      out_sb <= SIDEBAND_IDLE;
    end else if (in_enable) begin
      out_sb  <= in_sb;
      out_num <= num_next;
      out_rem <= q_bit ? rem_sub[DIVIDER_WIDTH-1:0] : rem_shift[DIVIDER_WIDTH-1:0];
      out_den <= in_den;
      out_tag <= in_tag;
    end
  end

endmodule

// File: rtl/divider_pipe_sx.sv
// Fully pipelined unsigned/signed integer divider, one operation per enabled
// cycle, latency divider_latency(DIVIDEND_WIDTH) enabled cycles.
// Macro DIVIDER_PIPE_SX_SIGNED_EN: when defined, in_signed selects two's
// complement division; when undefined every operation is unsigned and
// out_overflow is held at 0.
// Ports:
//   in_clk, reset (sync, active-high), in_enable (0 freezes everything)
//   in_data_valid, in_signed, in_dividend, in_divider, in_tag : operation
//   out_data_valid, out_quotient, out_remainder, out_tag      : result
//   out_div_zero, out_overflow                                : result flags
module divider_pipe_sx
  import divider_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = 8,
  parameter int DIVIDER_WIDTH  = 8,
  parameter int TAG_WIDTH      = 4
) (
  input  logic                      in_clk,
  input  logic                      reset,
  input  logic                      in_enable,
  input  logic                      in_data_valid,
  input  logic                      in_signed,
  input  logic [DIVIDEND_WIDTH-1:0] in_dividend,
  input  logic [DIVIDER_WIDTH-1:0]  in_divider,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  output logic                      out_data_valid,
  output logic [DIVIDEND_WIDTH-1:0] out_quotient,
  output logic [DIVIDER_WIDTH-1:0]  out_remainder,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic                      out_div_zero,
  output logic                      out_overflow
);

  localparam int N  = DIVIDEND_WIDTH;
  localparam int DW = DIVIDER_WIDTH;
`ifdef DIVIDER_PIPE_SX_SIGNED_EN
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};
`endif

  // Index 0 is the input register, N is the last division step.
  logic [N-1:0]         num_p [0:N];
  logic [DW-1:0]        rem_p [0:N];
  logic [DW-1:0]        den_p [0:N];
  sideband_t            sb_p  [0:N];
  logic [TAG_WIDTH-1:0] tag_p [0:N];

  sideband_t      sb_in;
  logic [N-1:0]   num_in;
  logic [DW-1:0]  den_in;
  logic [N-1:0]   q_fix;
  logic [DW-1:0]  r_fix;

  // A zero divisor skips the magnitude conversion so the raw dividend drops
  // straight out as the remainder.
  always_comb begin
    sb_in          = SIDEBAND_IDLE;
    sb_in.valid    = in_data_valid;
    sb_in.div_zero = in_data_valid && (in_divider == '0);
    num_in         = in_dividend;
    den_in         = in_divider;
`ifdef DIVIDER_PIPE_SX_SIGNED_EN
    sb_in.is_signed = in_signed;
    if (in_signed && !sb_in.div_zero) begin
      sb_in.q_neg    = in_dividend[N-1] ^ in_divider[DW-1];
      sb_in.r_neg    = in_dividend[N-1];
      sb_in.overflow = in_data_valid && (in_dividend == MOST_NEG) && (in_divider == '1);
      num_in         = in_dividend[N-1] ? -in_dividend : in_dividend;
      den_in         = in_divider[DW-1] ? -in_divider : in_divider;
    end
`endif
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      sb_p[0] <= SIDEBAND_IDLE;
    end else if (in_enable) begin
      sb_p[0]  <= sb_in;
      num_p[0] <= num_in;
      den_p[0] <= den_in;
      tag_p[0] <= in_tag;
    end
  end

  assign rem_p[0] = '0;

  for (genvar i = 0; i < N; i++) begin : g_step
    divider_pipe_stage #(
      .DIVIDEND_WIDTH(N),
      .DIVIDER_WIDTH (DW),
      .TAG_WIDTH     (TAG_WIDTH),
      .STAGE         (i)
    ) u_stage (
      .in_clk   (in_clk),
      .reset    (reset),
      .in_enable(in_enable),
      .in_num   (num_p[i]),
      .in_rem   (rem_p[i]),
      .in_den   (den_p[i]),
      .in_sb    (sb_p[i]),
      .in_tag   (tag_p[i]),
      .out_num  (num_p[i+1]),
      .out_rem  (rem_p[i+1]),
      .out_den  (den_p[i+1]),
      .out_sb   (sb_p[i+1]),
      .out_tag  (tag_p[i+1])
    );
  end

  always_comb begin
    q_fix = num_p[N];
    r_fix = rem_p[N];
`ifdef DIVIDER_PIPE_SX_SIGNED_EN
    if (sb_p[N].q_neg) q_fix = -num_p[N];
    if (sb_p[N].r_neg) r_fix = -rem_p[N];
    if (sb_p[N].overflow) begin
      q_fix = MOST_NEG;
      r_fix = '0;
    end
`endif
    if (sb_p[N].div_zero) begin
      q_fix = '1;
      r_fix = rem_p[N];
    end
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      out_data_valid <= 1'b0;
      out_quotient   <= '0;
      out_remainder  <= '0;
      out_tag        <= '0;
      out_div_zero   <= 1'b0;
    end else if (in_enable) begin
      out_data_valid <= sb_p[N].valid;
      out_quotient   <= q_fix;
      out_remainder  <= r_fix;
      out_tag        <= tag_p[N];
      out_div_zero   <= sb_p[N].valid && sb_p[N].div_zero;
    end
  end

`ifdef DIVIDER_PIPE_SX_SIGNED_EN
  always_ff @(posedge in_clk) begin
    if (reset)          out_overflow <= 1'b0;
    else if (in_enable) out_overflow <= sb_p[N].valid && sb_p[N].overflow;
  end
`else
  assign out_overflow = 1'b0;
`endif

  // Carried for lockstep but not needed past the last step.
  logic unused_tail;
  assign unused_tail = &{1'b0, den_p[N], sb_p[N].is_signed, sb_p[N].overflow,
                         sb_p[N].q_neg, sb_p[N].r_neg, in_signed};

endmodule

// File: tb/tb_divider_pipe_sx.sv
module tb_divider_pipe_sx;
  localparam int DN = 8;
  localparam int DW = 8;
  localparam int TW = 4;
  localparam int L  = DN + 2;

  logic          in_clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_enable = 1'b0;
  logic          in_data_valid = 1'b0;
  logic          in_signed = 1'b0;
  logic [DN-1:0] in_dividend = '0;
  logic [DW-1:0] in_divider = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_data_valid;
  logic [DN-1:0] out_quotient;
  logic [DW-1:0] out_remainder;
  logic [TW-1:0] out_tag;
  logic          out_div_zero;
  logic          out_overflow;

  divider_pipe_sx #(.DIVIDEND_WIDTH(DN), .DIVIDER_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .in_clk(in_clk), .reset(reset), .in_enable(in_enable),
    .in_data_valid(in_data_valid), .in_signed(in_signed),
    .in_dividend(in_dividend), .in_divider(in_divider), .in_tag(in_tag),
    .out_data_valid(out_data_valid), .out_quotient(out_quotient),
    .out_remainder(out_remainder), .out_tag(out_tag),
    .out_div_zero(out_div_zero), .out_overflow(out_overflow));

  always #5 in_clk = ~in_clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic          valid;
    logic [DN-1:0] q;
    logic [DW-1:0] r;
    logic [TW-1:0] tag;
    logic          dz;
    logic          ov;
  } exp_t;

  // Reference: plain integer division, C-style truncation toward zero.
  function automatic exp_t model(input bit s, input logic [DN-1:0] a,
                                 input logic [DW-1:0] b, input logic [TW-1:0] t);
    exp_t   e;
    longint ia, ib, qq, rr;
`ifndef DIVIDER_PIPE_SX_SIGNED_EN
    s = 1'b0;
`endif
    e = '0;
    e.valid = 1'b1;
    e.tag = t;
    ia = s ? longint'($signed(a)) : longint'(a);
    ib = s ? longint'($signed(b)) : longint'(b);
    if (ib == 0) begin
      e.q = '1;
      e.r = a[DW-1:0];
      e.dz = 1'b1;
    end else if (s && ia == -(longint'(1) << (DN-1)) && ib == -1) begin
      e.q = a;
      e.r = '0;
      e.ov = 1'b1;
    end else begin
      qq = ia / ib;
      rr = ia % ib;
      e.q = qq[DN-1:0];
      e.r = rr[DW-1:0];
    end
    return e;
  endfunction

  // Timing model: expectations advance one slot per enabled edge.
  exp_t pipe[$];
  exp_t expo;
  bit   armed = 1'b0;

  always @(posedge in_clk) begin
    exp_t          e;
    bit            frozen, was_reset;
    logic [DN-1:0] pq;
    logic [DW-1:0] pr;
    logic [TW-1:0] pt;
    logic          pv;
    pq = out_quotient; pr = out_remainder; pt = out_tag; pv = out_data_valid;
    frozen = 1'b0;
    was_reset = 1'b0;
    if (reset) begin
      pipe.delete();
      repeat (L - 1) pipe.push_back('0);
      expo = '0;
      armed = 1'b1;
      was_reset = 1'b1;
    end else if (armed && in_enable) begin
      e = in_data_valid ? model(in_signed, in_dividend, in_divider, in_tag) : '0;
      pipe.push_back(e);
      expo = pipe.pop_front();
    end else if (armed) begin
      frozen = 1'b1;
    end
    #1;
    if (armed) begin
      chk("valid", out_data_valid, expo.valid);
      chk("div_zero", out_div_zero, expo.dz);
      chk("overflow", out_overflow, expo.ov);
      if (expo.valid) begin
        chk("quotient", out_quotient, expo.q);
        chk("remainder", out_remainder, expo.r);
        chk("tag", out_tag, expo.tag);
      end
      if (was_reset)
        chk("reset_zero", {out_quotient, out_remainder, out_tag}, '0);
      if (frozen)
        chk("frozen", {pv, pq, pr, pt}, {out_data_valid, out_quotient, out_remainder, out_tag});
    end
  end

  // Single directed operation; checks literal results and exact latency.
  task automatic run_one(input bit s, input logic [DN-1:0] a, input logic [DW-1:0] b,
                         input logic [TW-1:0] t, input logic [DN-1:0] eq,
                         input logic [DW-1:0] er, input logic edz, input logic eov);
    int n;
    @(negedge in_clk);
    in_enable = 1'b1;
    in_data_valid = 1'b1;
    in_signed = s;
    in_dividend = a;
    in_divider = b;
    in_tag = t;
    n = 0;
    do begin
      @(posedge in_clk);
      #1;
      n++;
      in_data_valid = 1'b0;
    end while (!out_data_valid && n < 30);
    chk("dir_latency", n, L);
    chk("dir_quotient", out_quotient, eq);
    chk("dir_remainder", out_remainder, er);
    chk("dir_tag", out_tag, t);
    chk("dir_div_zero", out_div_zero, edz);
    chk("dir_overflow", out_overflow, eov);
  endtask

  initial begin
    int ops;
    // Reset held with in_enable low: must still clear.
    repeat (3) @(negedge in_clk);
    reset = 1'b0;
    in_enable = 1'b1;
    @(posedge in_clk);
    #1;
    chk("post_reset_valid", out_data_valid, 1'b0);

    run_one(1'b0, 8'd200, 8'd7, 4'd3, 8'd28, 8'd4, 1'b0, 1'b0);
    run_one(1'b0, 8'd45, 8'd0, 4'd5, 8'hFF, 8'h2D, 1'b1, 1'b0);
    run_one(1'b1, 8'd45, 8'd0, 4'd6, 8'hFF, 8'h2D, 1'b1, 1'b0);
`ifdef DIVIDER_PIPE_SX_SIGNED_EN
    run_one(1'b1, 8'hF9, 8'h02, 4'd1, 8'hFD, 8'hFF, 1'b0, 1'b0);
    run_one(1'b1, 8'h07, 8'hFE, 4'd2, 8'hFD, 8'h01, 1'b0, 1'b0);
    run_one(1'b1, 8'h80, 8'hFF, 4'd7, 8'h80, 8'h00, 1'b0, 1'b1);
    run_one(1'b1, 8'hF9, 8'hFE, 4'd8, 8'h03, 8'hFF, 1'b0, 1'b0);
`else
    run_one(1'b1, 8'hF9, 8'h02, 4'd1, 8'd124, 8'd1, 1'b0, 1'b0);
`endif

    // Random back-to-back traffic with enable dropouts.
    ops = 0;
    while (ops < 2000) begin
      @(negedge in_clk);
      in_enable = ($urandom_range(0, 99) >= 20);
      in_data_valid = ($urandom_range(0, 9) != 0);
      in_signed = $urandom_range(0, 1);
      in_dividend = ($urandom_range(0, 15) == 0) ? 8'h80 : 8'($urandom);
      case ($urandom_range(0, 15))
        0: in_divider = '0;
        1: in_divider = '1;
        default: in_divider = 8'($urandom);
      endcase
      in_tag = 4'($urandom);
      if (in_enable && in_data_valid) ops++;
    end
    @(negedge in_clk);
    in_enable = 1'b1;
    in_data_valid = 1'b0;
    repeat (L + 2) @(negedge in_clk);

    // Reset with six operations in flight.
    for (int i = 0; i < 6; i++) begin
      in_data_valid = 1'b1;
      in_signed = 1'b0;
      in_dividend = 8'(100 + i);
      in_divider = 8'd3;
      in_tag = 4'(i);
      @(negedge in_clk);
    end
    in_data_valid = 1'b0;
    reset = 1'b1;
    @(posedge in_clk);
    #1;
    chk("reset_flush_valid", out_data_valid, 1'b0);
    @(negedge in_clk);
    reset = 1'b0;
    repeat (L + 5) @(negedge in_clk);
    run_one(1'b0, 8'd200, 8'd7, 4'd9, 8'd28, 8'd4, 1'b0, 1'b0);
    repeat (3) @(negedge in_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
